// File: rtl/gbuff_pkg.sv
// Shared types for the global-buffer stream blocks (reader and writer).
package gbuff_pkg;

   typedef enum logic [1:0] {
      GSR_IDLE,
      GSR_RUN,
      GSR_DRAIN,
      GSR_DONE
   } gsr_state_e;

   localparam int GSR_FIFO_DEPTH = 2;

endpackage

// File: rtl/gbuff_stream_reader_if.sv
// Valid/ready word stream with a last-beat marker.
interface gbuff_stream_reader_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 valid;
   logic                 ready;
   logic [DATA_BITS-1:0] data;
   logic                 last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/gbuff_skid_fifo2.sv
// Two-entry synchronous FIFO absorbing the buffer read latency under backpressure.
module gbuff_skid_fifo2
   import gbuff_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic [DATA_BITS-1:0] head_o,
   output logic                 full_o,
   output logic                 empty_o
);

   logic [DATA_BITS-1:0] r_mem [GSR_FIFO_DEPTH];
   logic                 r_wptr;
   logic                 r_rptr;
   logic [1:0]           r_count;
   logic                 w_do_push;
   logic                 w_do_pop;

   assign full_o    = (r_count == 2'(GSR_FIFO_DEPTH));
   assign empty_o   = (r_count == 2'd0);
   assign head_o    = r_mem[r_rptr];
   assign w_do_pop  = pop_i & ~empty_o;
   // A full FIFO may still accept a push when the head leaves on the same edge.
   assign w_do_push = push_i & (~full_o | w_do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= data_i;
            r_wptr        <= ~r_wptr;
         end
         if (w_do_pop) begin
            r_rptr <= ~r_rptr;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + 2'd1;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - 2'd1;
         end
      end
   end

endmodule

// File: rtl/gbuff_stream_reader.sv
// Streams a contiguous tile from the global buffer read port onto a valid/ready stream.
module gbuff_stream_reader
   import gbuff_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int LEN_BITS  = ADDR_BITS + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [ADDR_BITS-1:0] base_i,
   input  logic [LEN_BITS-1:0]  len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 gb_wr_en_o,
   output logic [ADDR_BITS-1:0] gb_index_o,
   input  logic [DATA_BITS-1:0] gb_data_i,
   gbuff_stream_reader_if.master m_stream
);

   gsr_state_e           r_state;
   gsr_state_e           w_state_next;
   logic [ADDR_BITS-1:0] r_addr;
   logic [ADDR_BITS-1:0] r_index_hold;
   logic [LEN_BITS-1:0]  r_len;
   logic [LEN_BITS-1:0]  r_issued;
   logic [LEN_BITS-1:0]  r_popped;
   logic                 r_inflight;
   logic                 w_accept;
   logic                 w_issue;
   logic                 w_pop;
   logic                 w_credit;
   logic [1:0]           w_occ;
   logic [2:0]           w_pending;
   logic                 w_full;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_head;

   assign w_accept = (r_state == GSR_IDLE) & start_i;
   assign w_pop    = m_stream.valid & m_stream.ready;

   // Words held or in flight, minus the one leaving now, must leave a free FIFO slot.
   assign w_occ     = {w_full, ~w_full & ~w_empty};
   assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};
   assign w_credit  = w_pending < (3'(GSR_FIFO_DEPTH) + {2'b00, w_pop});
   assign w_issue   = (r_state == GSR_RUN) & (r_issued != r_len) & w_credit;

   assign gb_wr_en_o = 1'b0;
   assign gb_index_o = w_issue ? r_addr : r_index_hold;
   assign busy_o     = (r_state != GSR_IDLE);
   assign done_o     = (r_state == GSR_DONE);

   assign m_stream.valid = ~w_empty;
   assign m_stream.data  = w_head;
   assign m_stream.last  = ~w_empty & (r_popped == (r_len - LEN_BITS'(1)));

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         GSR_IDLE: begin
            if (start_i) begin
               w_state_next = (len_i == '0) ? GSR_DONE : GSR_RUN;
            end
         end
         GSR_RUN: begin
            if (r_issued == r_len) begin
               w_state_next = GSR_DRAIN;
            end
         end
         GSR_DRAIN: begin
            if (w_pop && m_stream.last) begin
               w_state_next = GSR_DONE;
            end
         end
         GSR_DONE: w_state_next = GSR_IDLE;
         default:  w_state_next = GSR_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= GSR_IDLE;
         r_addr       <= '0;
         r_index_hold <= '0;
         r_len        <= '0;
         r_issued     <= '0;
         r_popped     <= '0;
         r_inflight   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_inflight <= w_issue;
         if (w_accept) begin
            r_addr   <= base_i;
            r_len    <= len_i;
            r_issued <= '0;
            r_popped <= '0;
         end else begin
            if (w_issue) begin
               r_addr       <= r_addr + ADDR_BITS'(1);
               r_index_hold <= r_addr;
               r_issued     <= r_issued + LEN_BITS'(1);
            end
            if (w_pop) begin
               r_popped <= r_popped + LEN_BITS'(1);
            end
         end
      end
   end

   gbuff_skid_fifo2 #(
      .DATA_BITS(DATA_BITS)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (r_inflight),
      .pop_i  (w_pop),
      .data_i (gb_data_i),
      .head_o (w_head),
      .full_o (w_full),
      .empty_o(w_empty)
   );

endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Scoreboard bench for gbuff_stream_reader against a 1-cycle-latency buffer model.
module tb_gbuff_stream_reader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] base;
   logic [8:0] len;
   logic       busy;
   logic       done;
   logic       gb_wr_en;
   logic [7:0] gb_index;
   logic [7:0] gb_data;
   logic [7:0] mem [256];

   gbuff_stream_reader_if #(.DATA_BITS(8)) m_if ();

   gbuff_stream_reader #(
      .ADDR_BITS(8),
      .DATA_BITS(8),
      .LEN_BITS (9)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .base_i    (base),
      .len_i     (len),
      .busy_o    (busy),
      .done_o    (done),
      .gb_wr_en_o(gb_wr_en),
      .gb_index_o(gb_index),
      .gb_data_i (gb_data),
      .m_stream  (m_if)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int fv_cyc   = -1;
   int done_cnt = 0;
   int busy_cnt = 0;
   int valid_cnt = 0;
   int rdy_mode = 0;
   logic [3:0] rdy_pat = 4'b1001;
   logic [8:0] sb [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;

   always @(posedge clk) gb_data <= mem[gb_index];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic l);
      sb.push_back({l, d});
   endtask

   initial begin
      m_if.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_if.ready = 1'b1;
            1:       m_if.ready = rdy_pat[cyc[1:0]];
            default: m_if.ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      logic [8:0] e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (m_if.valid) valid_cnt++;
            if (m_if.valid && fv_cyc < 0) fv_cyc = cyc;
            if (prev_stall) begin
               chk("stall_valid_hold", int'(m_if.valid), 1);
               chk("stall_data_hold", int'(m_if.data), int'(prev_data));
            end
            if (m_if.valid && m_if.ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_beat", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("beat_data", int'(m_if.data), int'(e[7:0]));
                  chk("beat_last", int'(m_if.last), int'(e[8]));
               end
            end
            prev_stall = m_if.valid & ~m_if.ready;
            prev_data  = m_if.data;
         end
      end
   end

   task automatic run_tile(input logic [7:0] b, input logic [8:0] l, input bit auto_push,
                           input bit timing, input int poke);
      int  c0;
      bit  got;
      if (auto_push) begin
         for (int i = 0; i < int'(l); i++) push_exp(8'(int'(b) + i) ^ 8'hA5, i == int'(l) - 1);
      end
      fv_cyc = -1;
      @(posedge clk);
      #1;
      start = 1'b1;
      base  = b;
      len   = l;
      @(posedge clk);
      #1;
      start = 1'b0;
      base  = 8'h99;
      len   = 9'd3;
      c0 = cyc;
      got = 1'b0;
      for (int k = 0; k < 2000 && !got; k++) begin
         @(negedge clk);
         if (k == poke && poke > 0) start = 1'b1;
         else start = 1'b0;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      if (!got) begin
         chk("done_timeout", 0, 1);
      end else if (timing) begin
         chk("done_latency", cyc - c0, (l == 0) ? 0 : int'(l) + 2);
         if (l != 0) chk("first_valid_latency", fv_cyc - c0, 2);
      end
      @(negedge clk);
      chk("done_single_pulse", int'(done), 0);
      chk("idle_after_done", int'(busy), 0);
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      int idx_before;
      int busy_before;
      int valid_before;
      int done_before;
      rst   = 1'b1;
      start = 1'b0;
      base  = '0;
      len   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_valid", int'(m_if.valid), 0);
      chk("rst_last", int'(m_if.last), 0);
      chk("rst_index", int'(gb_index), 0);
      chk("rst_wr_en", int'(gb_wr_en), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Test 1: hand-computed A5^10..A5^13.
      push_exp(8'hB5, 1'b0);
      push_exp(8'hB4, 1'b0);
      push_exp(8'hB7, 1'b0);
      push_exp(8'hB6, 1'b1);
      run_tile(8'h10, 9'd4, 1'b0, 1'b1, 0);

      // Test 2: index wrap FE,FF,00,01.
      push_exp(8'h5B, 1'b0);
      push_exp(8'h5A, 1'b0);
      push_exp(8'hA5, 1'b0);
      push_exp(8'hA4, 1'b1);
      run_tile(8'hFE, 9'd4, 1'b0, 1'b1, 0);

      // Test 3: ready pattern 1,0,0,1 repeating.
      rdy_mode = 1;
      run_tile(8'h30, 9'd8, 1'b1, 1'b0, 0);
      rdy_mode = 0;

      // Test 4: zero-length tile.
      idx_before   = int'(gb_index);
      busy_before  = busy_cnt;
      valid_before = valid_cnt;
      run_tile(8'h77, 9'd0, 1'b1, 1'b1, 0);
      chk("len0_busy_cycles", busy_cnt - busy_before, 1);
      chk("len0_no_valid", valid_cnt - valid_before, 0);
      chk("len0_index_held", int'(gb_index), idx_before);

      // Test 5a: start pulsed mid-tile is ignored.
      run_tile(8'h20, 9'd6, 1'b1, 1'b1, 3);

      // Test 5b: asynchronous reset mid-tile.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      start = 1'b1;
      base  = 8'h50;
      len   = 9'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      chk("pre_rst_valid", int'(m_if.valid), 1);
      done_before = done_cnt;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", int'(m_if.valid), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_last", int'(m_if.last), 0);
      chk("async_rst_index", int'(gb_index), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      rdy_mode = 0;
      repeat (4) @(negedge clk);
      chk("rst_no_done", done_cnt - done_before, 0);
      chk("rst_idle", int'(busy), 0);
      run_tile(8'h40, 9'd3, 1'b1, 1'b1, 0);

      // Test 6: whole buffer.
      run_tile(8'h00, 9'd256, 1'b1, 1'b1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
